// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: parity modes, transmitter FSM states
// and a width helper for sizing counters.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Bits needed to hold 0..v-1, never less than one.
    function automatic int CLOG2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: counts 0..DIV-1 and flags the last count. Holds at zero
// while clr is high so a bit period starts cleanly on the following cycle.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = CLOG2(DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: valid/ready word intake, internal baud divider, frames of
// START, WIDTH data bits LSB first, optional parity and 1 or 2 stop bits.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 16000000,
    parameter int BAUD       = 9600,
    parameter int WIDTH      = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx,
    output logic             busy
);

    localparam int DIV = CLOCK_FREQ / BAUD;
    localparam int BW  = CLOG2(WIDTH);

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_core: CLOCK_FREQ/BAUD must be at least 2");
    end
    if (WIDTH < 5 || WIDTH > 9) begin : g_bad_width
        $error("uart_tx_core: WIDTH must be 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_core: STOP_BITS must be 1 or 2");
    end
    if (PARITY != PARITY_NONE && PARITY != PARITY_EVEN && PARITY != PARITY_ODD) begin : g_bad_par
        $error("uart_tx_core: PARITY must be 0, 1 or 2");
    end

    tx_state_e        state_q, state_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             stop_q, stop_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             par_q, par_d;
    logic             tx_q, tx_d;
    logic             tick;

    // Counter is parked at zero in IDLE, so every bit period after acceptance is exactly DIV clocks.
    uart_baud_gen #(.DIV(DIV)) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q == ST_IDLE),
        .tick  (tick)
    );

    assign tx_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign tx       = tx_q;

    // tx_d is derived from the next state so the line changes on the same edge as the FSM.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        tx_d    = tx_q;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (tx_valid) begin
                    state_d = ST_START;
                    shreg_d = tx_data;
                    par_d   = (^tx_data) ^ (PARITY == PARITY_ODD);
                    bit_d   = '0;
                    stop_d  = 1'b0;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    tx_d    = shreg_q[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_q == BW'(WIDTH - 1)) begin
                        if (PARITY != PARITY_NONE) begin
                            state_d = ST_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (stop_q == 1'(STOP_BITS - 1)) state_d = ST_IDLE;
                    else                             stop_d  = stop_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: four configurations driven with random and fixed
// words, each frame compared cycle by cycle against a bit-slot model.
module tb_uart_tx_core;

    localparam int DIV = 4;
    localparam int NI  = 4;
    localparam int CW [NI] = '{8, 8, 8, 7};
    localparam int CP [NI] = '{0, 1, 2, 0};
    localparam int CS [NI] = '{1, 1, 1, 2};

    logic       clk;
    logic       rst_n;
    logic [8:0] data_r  [NI];
    logic       valid_r [NI];
    logic       txw     [NI];
    logic       rdy     [NI];
    logic       bsy     [NI];

    int checks;
    int failures;

    uart_tx_core #(.CLOCK_FREQ(16), .BAUD(4), .WIDTH(8), .STOP_BITS(1), .PARITY(0)) u0 (
        .clk(clk), .rst_n(rst_n), .tx_data(data_r[0][7:0]), .tx_valid(valid_r[0]),
        .tx_ready(rdy[0]), .tx(txw[0]), .busy(bsy[0]));
    uart_tx_core #(.CLOCK_FREQ(16), .BAUD(4), .WIDTH(8), .STOP_BITS(1), .PARITY(1)) u1 (
        .clk(clk), .rst_n(rst_n), .tx_data(data_r[1][7:0]), .tx_valid(valid_r[1]),
        .tx_ready(rdy[1]), .tx(txw[1]), .busy(bsy[1]));
    uart_tx_core #(.CLOCK_FREQ(16), .BAUD(4), .WIDTH(8), .STOP_BITS(1), .PARITY(2)) u2 (
        .clk(clk), .rst_n(rst_n), .tx_data(data_r[2][7:0]), .tx_valid(valid_r[2]),
        .tx_ready(rdy[2]), .tx(txw[2]), .busy(bsy[2]));
    uart_tx_core #(.CLOCK_FREQ(16), .BAUD(4), .WIDTH(7), .STOP_BITS(2), .PARITY(0)) u3 (
        .clk(clk), .rst_n(rst_n), .tx_data(data_r[3][6:0]), .tx_valid(valid_r[3]),
        .tx_ready(rdy[3]), .tx(txw[3]), .busy(bsy[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    function automatic int nbits(input int i);
        return 1 + CW[i] + ((CP[i] != 0) ? 1 : 0) + CS[i];
    endfunction

    // Line level the frame rules give for bit slot s of word w on instance i.
    function automatic logic exp_bit(input int i, input logic [8:0] w, input int s);
        logic p;
        if (s == 0) return 1'b0;
        if (s <= CW[i]) return w[s-1];
        if (CP[i] != 0 && s == CW[i] + 1) begin
            p = 1'b0;
            for (int j = 0; j < CW[i]; j++) p = p ^ w[j];
            return (CP[i] == 2) ? ~p : p;
        end
        return 1'b1;
    endfunction

    // Starts just after the acceptance edge; checks ncyc cycles (0 = whole frame).
    task automatic check_frame(input int i, input logic [8:0] w, input int ncyc, input bit tog);
        int n;
        n = nbits(i) * DIV;
        if (ncyc > 0 && ncyc < n) n = ncyc;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            checks++;
            if (txw[i] !== exp_bit(i, w, c / DIV)) begin
                failures++;
                $display("FAIL frame_tx inst=%0d word=%h cyc=%0d tx=%b expected=%b",
                         i, w, c, txw[i], exp_bit(i, w, c / DIV));
            end
            checks++;
            if (rdy[i] !== 1'b0 || bsy[i] !== 1'b1) begin
                failures++;
                $display("FAIL frame_hs inst=%0d cyc=%0d ready=%b busy=%b expected ready=0 busy=1",
                         i, c, rdy[i], bsy[i]);
            end
            if (tog) begin
                data_r[i]  = 9'($urandom);
                valid_r[i] = 1'($urandom);
            end
        end
        if (tog) valid_r[i] = 1'b0;
    endtask

    task automatic check_idle(input int i);
        @(negedge clk);
        checks++;
        if (rdy[i] !== 1'b1 || bsy[i] !== 1'b0 || txw[i] !== 1'b1) begin
            failures++;
            $display("FAIL idle inst=%0d ready=%b busy=%b tx=%b expected 1 0 1", i, rdy[i], bsy[i], txw[i]);
        end
    endtask

    task automatic accept(input int i, input logic [8:0] w, input bit hold);
        checks++;
        if (rdy[i] !== 1'b1) begin
            failures++;
            $display("FAIL accept_ready inst=%0d ready=%b expected 1", i, rdy[i]);
        end
        data_r[i]  = w;
        valid_r[i] = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) valid_r[i] = 1'b0;
    endtask

    task automatic send(input int i, input logic [8:0] w);
        accept(i, w, 1'b0);
        check_frame(i, w, 0, 1'b0);
        check_idle(i);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            valid_r[i] = 1'b0;
            data_r[i]  = '0;
        end
        #12;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (txw[i] !== 1'b1 || rdy[i] !== 1'b1 || bsy[i] !== 1'b0) begin
                failures++;
                $display("FAIL reset inst=%0d tx=%b ready=%b busy=%b expected 1 1 0", i, txw[i], rdy[i], bsy[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) check_idle(0);
    endtask

    task automatic test_basic();
        send(0, 9'h0A5);
        for (int k = 0; k < 3; k++) send(0, 9'($urandom));
    endtask

    task automatic test_parity();
        send(1, 9'h007);
        send(2, 9'h007);
        for (int k = 0; k < 3; k++) begin
            send(1, 9'($urandom));
            send(2, 9'($urandom));
        end
    endtask

    task automatic test_stop2();
        send(3, 9'h055);
        for (int k = 0; k < 2; k++) send(3, 9'($urandom));
    endtask

    task automatic test_back_to_back();
        accept(0, 9'h000, 1'b1);
        data_r[0] = 9'h0FF;
        check_frame(0, 9'h000, 0, 1'b0);
        check_idle(0);
        @(posedge clk);
        #1;
        valid_r[0] = 1'b0;
        check_frame(0, 9'h0FF, 0, 1'b0);
        check_idle(0);
    endtask

    task automatic test_reset_midframe();
        logic [8:0] w;
        w = 9'($urandom) & 9'h0F7;
        accept(0, w, 1'b0);
        check_frame(0, w, 4 * DIV + 2, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (txw[0] !== 1'b1 || rdy[0] !== 1'b1 || bsy[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid tx=%b ready=%b busy=%b expected 1 1 0", txw[0], rdy[0], bsy[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        check_idle(0);
        send(0, 9'h03C);
    endtask

    task automatic test_ignore_busy();
        for (int k = 0; k < 3; k++) begin
            logic [8:0] w;
            w = 9'($urandom);
            accept(0, w, 1'b0);
            check_frame(0, w, 0, 1'b1);
            check_idle(0);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_parity();
        test_stop2();
        test_back_to_back();
        test_reset_midframe();
        test_ignore_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
